// File: rtl/ft232h_sync_responder.sv
// Device-side model of the FT232H 245 synchronous FIFO: RX/TX byte buffers, packet gaps on TXE#.
// Optional protocol-violation counter enabled by defining FT232H_RESP_VIOL_CHK_EN.
module ft232h_sync_responder #(
   parameter int RX_DEPTH   = 64,
   parameter int TX_DEPTH   = 64,
   parameter int TX_PKT_LEN = 16,
   parameter int TX_GAP     = 4
) (
   input  logic       usb_clk_i,
   input  logic       reset_i,
   input  logic [7:0] usb_data_i,
   output logic [7:0] usb_data_o,
   output logic       usb_data_oe_o,
   output logic       usb_rxf_n_o,
   output logic       usb_txe_n_o,
   input  logic       usb_rd_n_i,
   input  logic       usb_wr_n_i,
   input  logic       usb_oe_n_i,
   input  logic [7:0] hin_data_i,
   input  logic       hin_valid_i,
   output logic       hin_ready_o,
   output logic [7:0] hout_data_o,
   output logic       hout_valid_o,
   input  logic       hout_ready_i,
   output logic [7:0] viol_cnt_o
);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int PKW = (TX_PKT_LEN > 1) ? $clog2(TX_PKT_LEN) : 1;
   localparam int GCW = $clog2(TX_GAP + 1);

   typedef enum logic {ST_OPEN, ST_GAP} gap_state_e;

   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [RAW-1:0] rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
   logic [RAW:0]   rx_cnt_q, rx_cnt_d;
   logic [TAW-1:0] tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
   logic [TAW:0]   tx_cnt_q, tx_cnt_d;
   logic [PKW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
   gap_state_e     gap_st_q, gap_st_d;
   logic           rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
   logic           hin_ready_q, hin_ready_d, oe_q, oe_d;
   logic           rx_push, rx_pop, tx_push, tx_pop, pkt_wrap;

   assign rx_push  = hin_valid_i & hin_ready_q;
   assign rx_pop   = ~usb_rd_n_i & ~usb_oe_n_i & ~rxf_n_q;
   assign tx_push  = ~usb_wr_n_i & ~txe_n_q;
   assign tx_pop   = (tx_cnt_q != '0) & hout_ready_i;
   assign pkt_wrap = (TX_PKT_LEN != 0) && tx_push && (pkt_cnt_q == PKW'(TX_PKT_LEN - 1));

   always_comb begin
      rx_wr_ptr_d = rx_wr_ptr_q + RAW'(rx_push);
      rx_rd_ptr_d = rx_rd_ptr_q + RAW'(rx_pop);
      rx_cnt_d    = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
      rxf_n_d     = (rx_cnt_d == '0);
      hin_ready_d = (rx_cnt_d < (RAW+1)'(RX_DEPTH));
      oe_d        = ~usb_oe_n_i;
      tx_wr_ptr_d = tx_wr_ptr_q + TAW'(tx_push);
      tx_rd_ptr_d = tx_rd_ptr_q + TAW'(tx_pop);
      tx_cnt_d    = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
   end

   // Gap FSM: no writes are accepted while in GAP, so the packet counter is idle there.
   always_comb begin
      gap_st_d  = gap_st_q;
      gap_cnt_d = gap_cnt_q;
      pkt_cnt_d = pkt_cnt_q;
      if (tx_push && TX_PKT_LEN != 0)
         pkt_cnt_d = pkt_wrap ? '0 : pkt_cnt_q + 1'b1;
      case (gap_st_q)
         ST_OPEN: begin
            if (pkt_wrap) begin
               gap_st_d  = ST_GAP;
               gap_cnt_d = '0;
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_d == GCW'(TX_GAP)) begin
               gap_st_d  = ST_OPEN;
               gap_cnt_d = '0;
            end
         end
         default: gap_st_d = ST_OPEN;
      endcase
      txe_n_d = (tx_cnt_d == (TAW+1)'(TX_DEPTH)) | (gap_st_d == ST_GAP);
   end

   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_rd_ptr_q <= '0;
         rx_wr_ptr_q <= '0;
         rx_cnt_q    <= '0;
         tx_rd_ptr_q <= '0;
         tx_wr_ptr_q <= '0;
         tx_cnt_q    <= '0;
         pkt_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         gap_st_q    <= ST_OPEN;
         rxf_n_q     <= 1'b1;
         txe_n_q     <= 1'b1;
         hin_ready_q <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_wr_ptr_q <= rx_wr_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_rd_ptr_q <= tx_rd_ptr_d;
         tx_wr_ptr_q <= tx_wr_ptr_d;
         tx_cnt_q    <= tx_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         gap_st_q    <= gap_st_d;
         rxf_n_q     <= rxf_n_d;
         txe_n_q     <= txe_n_d;
         hin_ready_q <= hin_ready_d;
         oe_q        <= oe_d;
      end
   end

   // Storage needs no reset: pointers and counts define which entries are live.
   always_ff @(posedge usb_clk_i) begin
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= hin_data_i;
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= usb_data_i;
   end

   assign usb_data_o    = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
   assign usb_data_oe_o = oe_q;
   assign usb_rxf_n_o   = rxf_n_q;
   assign usb_txe_n_o   = txe_n_q;
   assign hin_ready_o   = hin_ready_q;
   assign hout_valid_o  = (tx_cnt_q != '0);
   assign hout_data_o   = (tx_cnt_q != '0) ? tx_mem_q[tx_rd_ptr_q] : 8'h00;

`ifdef FT232H_RESP_VIOL_CHK_EN
   logic [7:0] viol_cnt_q, viol_cnt_d;
   logic       viol_hit;

   always_comb begin
      viol_hit   = (~usb_wr_n_i & txe_n_q) | (~usb_rd_n_i & rxf_n_q) |
                   (~usb_rd_n_i & usb_oe_n_i) | (~usb_wr_n_i & ~usb_oe_n_i);
      viol_cnt_d = viol_cnt_q;
      if (viol_hit && viol_cnt_q != 8'hFF) viol_cnt_d = viol_cnt_q + 8'd1;
   end

   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) viol_cnt_q <= 8'h00;
      else         viol_cnt_q <= viol_cnt_d;
   end

   assign viol_cnt_o = viol_cnt_q;
`else
   assign viol_cnt_o = 8'h00;
`endif
endmodule

// File: tb/tb_ft232h_sync_responder.sv
// Directed bench for ft232h_sync_responder: RX reads, TX packet gaps, full TX, streaming, reset, violations.
module tb_ft232h_sync_responder;
  logic       usb_clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] usb_data_i, usb_data_o, hin_data_i, hout_data_o, viol_cnt_o;
  logic       usb_data_oe_o, usb_rxf_n_o, usb_txe_n_o;
  logic       usb_rd_n_i, usb_wr_n_i, usb_oe_n_i;
  logic       hin_valid_i, hin_ready_o, hout_valid_o, hout_ready_i;

  int n_chk = 0, n_err = 0;
  int rcv [64];
  int rcv_n, acc, cyc;

  ft232h_sync_responder dut (
    .usb_clk_i(usb_clk_i), .reset_i(reset_i),
    .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_oe_o(usb_data_oe_o),
    .usb_rxf_n_o(usb_rxf_n_o), .usb_txe_n_o(usb_txe_n_o),
    .usb_rd_n_i(usb_rd_n_i), .usb_wr_n_i(usb_wr_n_i), .usb_oe_n_i(usb_oe_n_i),
    .hin_data_i(hin_data_i), .hin_valid_i(hin_valid_i), .hin_ready_o(hin_ready_o),
    .hout_data_o(hout_data_o), .hout_valid_o(hout_valid_o), .hout_ready_i(hout_ready_i),
    .viol_cnt_o(viol_cnt_o)
  );

  always #5 usb_clk_i = ~usb_clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rxf"},   32'(usb_rxf_n_o), 1);
    chk({tag, "_txe"},   32'(usb_txe_n_o), 1);
    chk({tag, "_oe"},    32'(usb_data_oe_o), 0);
    chk({tag, "_data"},  32'(usb_data_o), 0);
    chk({tag, "_hvld"},  32'(hout_valid_o), 0);
    chk({tag, "_hrdy"},  32'(hin_ready_o), 0);
    chk({tag, "_viol"},  32'(viol_cnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; usb_data_i = 8'h00; usb_rd_n_i = 1'b1; usb_wr_n_i = 1'b1; usb_oe_n_i = 1'b1;
    hin_data_i = 8'h00; hin_valid_i = 1'b0; hout_ready_i = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset_i = 1'b0;
    tick();
    chk("rel_txe", 32'(usb_txe_n_o), 0);
    chk("rel_hrdy", 32'(hin_ready_o), 1);

    // RX: load four bytes, read them out, then RD# held low on an empty buffer
    for (int i = 0; i < 4; i++) begin
      hin_valid_i = 1'b1; hin_data_i = 8'(8'h10 + i); tick();
    end
    hin_valid_i = 1'b0;
    chk("rx_rxf_lo", 32'(usb_rxf_n_o), 0);
    usb_oe_n_i = 1'b0; tick();
    chk("rx_oe", 32'(usb_data_oe_o), 1);
    usb_rd_n_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rx_data", 32'(usb_data_o), 32'(8'h10 + i));
      tick();
    end
    chk("rx_rxf_hi", 32'(usb_rxf_n_o), 1);
    chk("rx_empty_data", 32'(usb_data_o), 0);
    repeat (3) tick();
    chk("rx_nopop_rxf", 32'(usb_rxf_n_o), 1);
    usb_rd_n_i = 1'b1;
    hin_valid_i = 1'b1; hin_data_i = 8'hAA; tick(); hin_valid_i = 1'b0;
    chk("rx_after_data", 32'(usb_data_o), 32'h AA);
    chk("rx_after_rxf", 32'(usb_rxf_n_o), 0);
    usb_rd_n_i = 1'b0; tick(); usb_rd_n_i = 1'b1;
    chk("rx_after_pop", 32'(usb_rxf_n_o), 1);
    usb_oe_n_i = 1'b1; tick();

    // TX packet gap: 20 cycles of WR#, gap after byte 0x0F
    hout_ready_i = 1'b1; rcv_n = 0;
    for (int c = 0; c < 26; c++) begin
      if (hout_valid_o && rcv_n < 64) begin rcv[rcv_n] = int'(hout_data_o); rcv_n++; end
      if (c <= 20) chk("gap_txe", 32'(usb_txe_n_o), (c >= 16 && c < 20) ? 1 : 0);
      if (c < 20) begin usb_wr_n_i = 1'b0; usb_data_i = 8'(c); end
      else usb_wr_n_i = 1'b1;
      tick();
    end
    chk("gap_rcv_n", rcv_n, 16);
    for (int i = 0; i < 16 && i < rcv_n; i++) chk("gap_rcv", rcv[i], i);

    // TX full: 64 legal writes with the sink stalled, then a dropped 65th
    hout_ready_i = 1'b0; acc = 0; cyc = 0;
    while (acc < 64 && cyc < 300) begin
      if (!usb_txe_n_o) begin usb_wr_n_i = 1'b0; usb_data_i = 8'(acc); acc++; end
      else usb_wr_n_i = 1'b1;
      tick(); cyc++;
    end
    usb_wr_n_i = 1'b1;
    chk("fill_acc", acc, 64);
    chk("fill_txe", 32'(usb_txe_n_o), 1);
    usb_wr_n_i = 1'b0; usb_data_i = 8'hEE; tick(); usb_wr_n_i = 1'b1;
    repeat (6) tick();
    chk("full_txe", 32'(usb_txe_n_o), 1);
    chk("full_head", 32'(hout_data_o), 0);
    hout_ready_i = 1'b1; tick(); hout_ready_i = 1'b0;
    chk("pop_txe", 32'(usb_txe_n_o), 0);
    hout_ready_i = 1'b1; rcv_n = 0; cyc = 0;
    while (hout_valid_o && cyc < 100) begin
      if (rcv_n < 64) begin rcv[rcv_n] = int'(hout_data_o); rcv_n++; end
      tick(); cyc++;
    end
    hout_ready_i = 1'b0;
    chk("drain_n", rcv_n, 63);
    for (int i = 0; i < 63 && i < rcv_n; i++) chk("drain_data", rcv[i], i + 1);

    // RX streaming at count 2: push and pop every cycle
    hin_valid_i = 1'b1; hin_data_i = 8'h20; tick();
    hin_data_i = 8'h21; tick(); hin_valid_i = 1'b0;
    usb_oe_n_i = 1'b0; tick();
    for (int k = 0; k < 32; k++) begin
      hin_valid_i = 1'b1; hin_data_i = 8'(8'h22 + k); usb_rd_n_i = 1'b0;
      chk("stream_data", 32'(usb_data_o), 32'(8'h20 + k));
      tick();
    end
    hin_valid_i = 1'b0; usb_rd_n_i = 1'b1;
    chk("stream_end0", 32'(usb_data_o), 32'h40);
    usb_rd_n_i = 1'b0; tick();
    chk("stream_end1", 32'(usb_data_o), 32'h41);
    chk("stream_rxf1", 32'(usb_rxf_n_o), 0);
    tick();
    chk("stream_rxf0", 32'(usb_rxf_n_o), 1);
    usb_rd_n_i = 1'b1; usb_oe_n_i = 1'b1; tick();

    // Reset mid-burst with ten bytes buffered in each direction
    for (int i = 0; i < 10; i++) begin
      hin_valid_i = 1'b1; hin_data_i = 8'(8'h80 + i);
      usb_wr_n_i = 1'b0; usb_data_i = 8'(8'h90 + i);
      tick();
    end
    hin_valid_i = 1'b0; usb_wr_n_i = 1'b1;
    chk("pre_rst_hvld", 32'(hout_valid_o), 1);
    reset_i = 1'b1; #1;
    chk_reset_vals("mid_rst");
    tick(); tick();
    reset_i = 1'b0;
    tick();
    chk("post_rst_txe", 32'(usb_txe_n_o), 0);
    chk("post_rst_hrdy", 32'(hin_ready_o), 1);
    hout_ready_i = 1'b1; usb_oe_n_i = 1'b0;
    repeat (3) tick();
    chk("post_rst_hvld", 32'(hout_valid_o), 0);
    chk("post_rst_rxf", 32'(usb_rxf_n_o), 1);
    chk("post_rst_data", 32'(usb_data_o), 0);
    usb_oe_n_i = 1'b1; tick();

    // Violations: 3 writes into the gap, then 2 reads with OE# high on empty RX
    chk("viol_start", 32'(viol_cnt_o), 0);
    for (int c = 0; c < 19; c++) begin
      usb_wr_n_i = 1'b0; usb_data_i = 8'(c); tick();
    end
    usb_wr_n_i = 1'b1;
`ifdef FT232H_RESP_VIOL_CHK_EN
    chk("viol_wr", 32'(viol_cnt_o), 3);
`else
    chk("viol_wr", 32'(viol_cnt_o), 0);
`endif
    usb_rd_n_i = 1'b0; tick(); tick(); usb_rd_n_i = 1'b1;
    tick();
`ifdef FT232H_RESP_VIOL_CHK_EN
    chk("viol_total", 32'(viol_cnt_o), 5);
`else
    chk("viol_total", 32'(viol_cnt_o), 0);
`endif
    repeat (6) tick();
    chk("viol_gap_end_txe", 32'(usb_txe_n_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
